prim_ram_1p_init_adv: RTL and testbench
=======================================

Name: prim_ram_1p_init_adv

Overview:
Single-port RAM wrapper with per-byte odd parity, a built-in hardware initialisation engine and first-error address capture. Generalises the existing single-port advanced RAM wrapper to arbitrary byte-multiple width and to non-power-of-two depth, with optional output pipelining. It sits between a bus/CPU port and on-chip memory. Its request/grant handshake blocks accesses while the memory is being scrubbed to a parity-correct zero state.

Parameters:
Depth, 512, number of words; any value >= 2, need not be a power of two.
Width, 32, data bits per word; must be a multiple of 8.
EnableParity, 1, 1 = store one odd-parity bit per byte (storage width Width+Width/8); 0 = plain storage.
EnableOutputPipeline, 0, 1 = extra output register stage (read latency 2); 0 = read latency 1.
InitOnReset, 1, 1 = start the init sequence automatically on reset release; 0 = wait for init_req_i.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  access request
gnt_o  out  1  request accepted this cycle (combinational)
write_i  in  1  1 = write, 0 = read; sampled with req_i
addr_i  in  Aw = (Depth==1 ? 1 : clog2(Depth))  word address
wdata_i  in  Width  write data
wmask_i  in  Width  per-bit write enable
rdata_o  out  Width  read data
rvalid_o  out  1  rdata_o/rerror_o valid
rerror_o  out  2  [1] parity error, [0] always 0
init_req_i  in  1  start (re)initialisation
init_busy_o  out  1  init sequence in progress
init_done_o  out  1  sticky: last init completed
err_valid_o  out  1  sticky: error address captured
err_addr_o  out  Aw  address of first erroneous read
err_clr_i  in  1  clear err_valid_o

Behaviour:
- Clock is clk_i; reset is rst_ni, asynchronous assert, active-low.
- Reset values: gnt_o=0 (no request), rdata_o=0, rvalid_o=0, rerror_o=0, init_done_o=0, err_valid_o=0, err_addr_o=0. init_busy_o=1 if InitOnReset, else 0. Memory contents are not reset.
- FSM has two states, INIT and READY. Reset state is INIT if InitOnReset, else READY. Init counter resets to 0.
- In INIT, the block writes one word per cycle at address = counter: data 0, parity bits 1 (odd parity of a zero byte).
- After writing Depth-1, next state is READY, init_done_o=1 and the counter returns to 0. The sequence takes exactly Depth cycles.
- In READY with init_req_i=1: next state is INIT, init_done_o is cleared, gnt_o=0 that cycle (init has priority over req_i).
- init_req_i while in INIT is ignored. Reset asserted mid-init restarts the sequence from address 0.
- gnt_o = req_i & READY & ~init_req_i. Ungranted requests have no effect and produce no rvalid_o.
- Write: each data bit is updated where its wmask_i bit is 1. The parity bit of byte b is written as ~^wdata_i[8b+:8] only if &wmask_i[8b+:8]; otherwise the stored parity bit is unchanged.
- Read: rvalid_o is 1 exactly 1 cycle after a granted read (2 cycles if EnableOutputPipeline). Back-to-back reads are accepted every cycle.
- Parity check: rerror_o[1] = OR over bytes of (^{byte, parity} == 0). rerror_o is forced to 0 when rvalid_o=0 or EnableParity=0.
- Address >= Depth: request is granted; a write is dropped; a read returns rvalid_o=1, rdata_o=0, rerror_o=0.
- Error capture: on a read with rerror_o[1]=1 while err_valid_o=0, err_addr_o takes the read address (pipelined alongside the data) and err_valid_o is set.
- err_clr_i clears err_valid_o. If a capture and a clear occur in the same cycle, the capture wins and err_addr_o updates.
- err_addr_o holds its value while err_valid_o=1.
- Write followed by a read of the same address in the next cycle returns the new data.
- EnableParity=0: no parity storage; err_valid_o is never set.

Test Plan:
- Reset with InitOnReset=1, Depth=512 -> init_busy_o=1 for 512 cycles, then init_done_o=1. Reads of addresses 0, 255 and 511 return 0x00000000 with rerror_o=0.
- Full-mask write of 0xDEADBEEF to addr 5, then read addr 5 -> rvalid_o one cycle after gnt_o, rdata_o=0xDEADBEEF, rerror_o=0. With EnableOutputPipeline=1, same data 2 cycles after gnt_o.
- Write 0x000000AB to addr 7 with wmask_i=0x0000000F (partial byte), then read addr 7 -> rdata_o=0x0000000B, rerror_o=2'b10, err_valid_o=1, err_addr_o=7.
- Second parity error at addr 9 while err_valid_o=1 -> err_addr_o stays 7. err_clr_i asserted in the same cycle as the addr 9 error capture -> err_valid_o=1, err_addr_o=9.
- init_req_i and req_i asserted together in READY -> gnt_o=0. req_i held during init -> gnt_o=0 for Depth cycles, then 1. Reset pulsed at counter=100 -> init restarts, taking a full Depth cycles.
- Depth=300: read of addr 310 -> rvalid_o=1, rdata_o=0, rerror_o=0. Write to addr 310 leaves addresses 0..299 unchanged.

Source files
------------

// File: rtl/prim_ram_1p_init_adv.sv
// Single-port RAM with per-byte odd parity, a zero-scrub init engine and
// first-error address capture; read latency 1, or 2 with the output pipeline.
module prim_ram_1p_init_adv #(
  parameter int unsigned Depth                = 512,
  parameter int unsigned Width                = 32,
  parameter bit          EnableParity         = 1'b1,
  parameter bit          EnableOutputPipeline = 1'b0,
  parameter bit          InitOnReset          = 1'b1,
  localparam int unsigned Aw = (Depth == 1) ? 1 : $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic             write_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Width-1:0] wmask_i,
  output logic [Width-1:0] rdata_o,
  output logic             rvalid_o,
  output logic [1:0]       rerror_o,
  input  logic             init_req_i,
  output logic             init_busy_o,
  output logic             init_done_o,
  output logic             err_valid_o,
  output logic [Aw-1:0]    err_addr_o,
  input  logic             err_clr_i
);

  localparam int unsigned   NumBytes = Width / 8;
  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);
  localparam logic [Aw:0]   DepthW   = (Aw + 1)'(Depth);

  typedef enum logic {StInit, StReady} state_e;

  state_e        state_q, state_d;
  logic [Aw-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          init_we;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= InitOnReset ? StInit : StReady;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    init_we = 1'b0;
    unique case (state_q)
      StInit: begin
        init_we = 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = StReady;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + Aw'(1);
        end
      end
      StReady: begin
        if (init_req_i) begin
          state_d = StInit;
          done_d  = 1'b0;
        end
      end
      default: state_d = StReady;
    endcase
  end

  assign init_busy_o = (state_q == StInit);
  assign init_done_o = done_q;

  // init_req_i takes priority over a pending access
  assign gnt_o = req_i & (state_q == StReady) & ~init_req_i;

  logic in_range, we, re;
  assign in_range = ({1'b0, addr_i} < DepthW);
  assign we       = gnt_o & write_i & in_range;
  assign re       = gnt_o & ~write_i;

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (init_we) begin
      mem_q[cnt_q] <= '0;
    end else if (we) begin
      mem_q[addr_i] <= (mem_q[addr_i] & ~wmask_i) | (wdata_i & wmask_i);
    end
  end

  // A byte's parity bit is only rewritten when the whole byte is written
  logic [NumBytes-1:0] wpar, wpar_en, par_rd;

  always_comb begin
    wpar    = '0;
    wpar_en = '0;
    for (int b = 0; b < NumBytes; b++) begin
      wpar[b]    = ~^wdata_i[8*b +: 8];
      wpar_en[b] = &wmask_i[8*b +: 8];
    end
  end

  if (EnableParity) begin : g_par
    logic [NumBytes-1:0] par_q [Depth];

    always_ff @(posedge clk_i) begin
      if (init_we) begin
        par_q[cnt_q] <= '1;
      end else if (we) begin
        par_q[addr_i] <= (par_q[addr_i] & ~wpar_en) | (wpar & wpar_en);
      end
    end

    assign par_rd = par_q[addr_i];
  end else begin : g_nopar
    assign par_rd = '1;
  end

  logic                rvalid1_q;
  logic [Width-1:0]    rdata1_q;
  logic [NumBytes-1:0] rpar1_q;
  logic [Aw-1:0]       raddr1_q;

  // Out-of-range reads return zero data with correct parity
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid1_q <= 1'b0;
      rdata1_q  <= '0;
      rpar1_q   <= '1;
      raddr1_q  <= '0;
    end else begin
      rvalid1_q <= re;
      if (re) begin
        rdata1_q <= in_range ? mem_q[addr_i] : '0;
        rpar1_q  <= in_range ? par_rd : '1;
        raddr1_q <= addr_i;
      end
    end
  end

  logic [NumBytes-1:0] perr_byte;
  logic                perr1;

  always_comb begin
    perr_byte = '0;
    for (int b = 0; b < NumBytes; b++) begin
      perr_byte[b] = ~^{rdata1_q[8*b +: 8], rpar1_q[b]};
    end
  end

  assign perr1 = EnableParity & (|perr_byte);

  logic             out_valid, out_perr;
  logic [Width-1:0] out_data;
  logic [Aw-1:0]    out_addr;

  if (EnableOutputPipeline) begin : g_pipe
    logic             rvalid2_q, perr2_q;
    logic [Width-1:0] rdata2_q;
    logic [Aw-1:0]    raddr2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rvalid2_q <= 1'b0;
        perr2_q   <= 1'b0;
        rdata2_q  <= '0;
        raddr2_q  <= '0;
      end else begin
        rvalid2_q <= rvalid1_q;
        if (rvalid1_q) begin
          perr2_q  <= perr1;
          rdata2_q <= rdata1_q;
          raddr2_q <= raddr1_q;
        end
      end
    end

    assign out_valid = rvalid2_q;
    assign out_perr  = perr2_q;
    assign out_data  = rdata2_q;
    assign out_addr  = raddr2_q;
  end else begin : g_nopipe
    assign out_valid = rvalid1_q;
    assign out_perr  = perr1;
    assign out_data  = rdata1_q;
    assign out_addr  = raddr1_q;
  end

  assign rvalid_o = out_valid;
  assign rdata_o  = out_data;
  assign rerror_o = {out_valid & out_perr, 1'b0};

  logic          err_valid_q;
  logic [Aw-1:0] err_addr_q;
  logic          err_cap;

  // A capture coinciding with a clear wins and reloads the address
  assign err_cap = out_valid & out_perr & (~err_valid_q | err_clr_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else if (err_cap) begin
      err_valid_q <= 1'b1;
      err_addr_q  <= out_addr;
    end else if (err_clr_i) begin
      err_valid_q <= 1'b0;
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_prim_ram_1p_init_adv.sv
// Bench for prim_ram_1p_init_adv: two instances (512 words latency 1, 300 words
// latency 2) share stimulus and are checked every cycle against a word-array model.
module tb_prim_ram_1p_init_adv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, write, init_req, err_clr_a, err_clr_b;
  logic [8:0]  addr;
  logic [31:0] wdata, wmask;

  logic        gnt_a, rvalid_a, busy_a, done_a, errv_a;
  logic [31:0] rdata_a;
  logic [1:0]  rerror_a;
  logic [8:0]  erra_a;
  logic        gnt_b, rvalid_b, busy_b, done_b, errv_b;
  logic [31:0] rdata_b;
  logic [1:0]  rerror_b;
  logic [8:0]  erra_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prim_ram_1p_init_adv #(
    .Depth(512), .Width(32), .EnableParity(1'b1),
    .EnableOutputPipeline(1'b0), .InitOnReset(1'b1)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_a), .write_i(write),
    .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rdata_a),
    .rvalid_o(rvalid_a), .rerror_o(rerror_a), .init_req_i(init_req),
    .init_busy_o(busy_a), .init_done_o(done_a), .err_valid_o(errv_a),
    .err_addr_o(erra_a), .err_clr_i(err_clr_a)
  );

  prim_ram_1p_init_adv #(
    .Depth(300), .Width(32), .EnableParity(1'b1),
    .EnableOutputPipeline(1'b1), .InitOnReset(1'b1)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_b), .write_i(write),
    .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rdata_b),
    .rvalid_o(rvalid_b), .rerror_o(rerror_b), .init_req_i(init_req),
    .init_busy_o(busy_b), .init_done_o(done_b), .err_valid_o(errv_b),
    .err_addr_o(erra_b), .err_clr_i(err_clr_b)
  );

  // ---------------- behavioural model ----------------
  int        depth_k [2] = '{512, 300};
  int        lat_k   [2] = '{1, 2};
  bit [31:0] m_data  [2][512];
  bit [3:0]  m_par   [2][512];
  bit        m_ready [2];
  int        m_cnt   [2];
  bit        m_done  [2];
  bit        m_errv  [2];
  int        m_erra  [2];
  // read results in flight, index = cycles since the read was granted - 1
  bit        pv [2][2];
  bit [31:0] pd [2][2];
  bit        pe [2][2];
  int        pa [2][2];

  function automatic bit parity_bad(input bit [31:0] d, input bit [3:0] p);
    bit bad = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if ((($countones(d[8*b +: 8]) + int'(p[b])) % 2) == 0) bad = 1'b1;
    end
    return bad;
  endfunction

  task automatic model_step(input int k);
    int o   = lat_k[k] - 1;
    bit clr = (k == 0) ? err_clr_a : err_clr_b;
    int a   = int'(addr);
    if (pv[k][o] && pe[k][o] && (!m_errv[k] || clr)) begin
      m_errv[k] = 1'b1;
      m_erra[k] = pa[k][o];
    end else if (clr) begin
      m_errv[k] = 1'b0;
    end
    pv[k][1] = pv[k][0]; pd[k][1] = pd[k][0]; pe[k][1] = pe[k][0]; pa[k][1] = pa[k][0];
    pv[k][0] = 1'b0;
    if (!m_ready[k]) begin
      m_data[k][m_cnt[k]] = '0;
      m_par[k][m_cnt[k]]  = 4'hF;
      if (m_cnt[k] == depth_k[k] - 1) begin
        m_ready[k] = 1'b1;
        m_done[k]  = 1'b1;
        m_cnt[k]   = 0;
      end else begin
        m_cnt[k]++;
      end
    end else if (init_req) begin
      m_ready[k] = 1'b0;
      m_done[k]  = 1'b0;
    end else if (req) begin
      if (write) begin
        if (a < depth_k[k]) begin
          for (int i = 0; i < 32; i++) if (wmask[i]) m_data[k][a][i] = wdata[i];
          for (int b = 0; b < 4; b++)
            if (wmask[8*b +: 8] == 8'hFF)
              m_par[k][a][b] = ($countones(wdata[8*b +: 8]) % 2) == 0;
        end
      end else begin
        pv[k][0] = 1'b1;
        pa[k][0] = a;
        if (a < depth_k[k]) begin
          pd[k][0] = m_data[k][a];
          pe[k][0] = parity_bad(m_data[k][a], m_par[k][a]);
        end else begin
          pd[k][0] = '0;
          pe[k][0] = 1'b0;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_ready[k] = 1'b0; m_cnt[k] = 0; m_done[k] = 1'b0;
        m_errv[k] = 1'b0; m_erra[k] = 0;
        pv[k][0] = 1'b0; pv[k][1] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  // ---------------- comparison ----------------
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic check_dut(input int k, input logic g, input logic rv, input logic [31:0] rd,
                           input logic [1:0] re, input logic bz, input logic dn,
                           input logic ev, input logic [8:0] ea);
    int    o = lat_k[k] - 1;
    string s = (k == 0) ? "a" : "b";
    cmp({"gnt_", s}, 32'(g), 32'(req & m_ready[k] & ~init_req));
    cmp({"rvalid_", s}, 32'(rv), 32'(pv[k][o]));
    if (pv[k][o]) begin
      cmp({"rdata_", s}, rd, pd[k][o]);
      cmp({"rerror_", s}, 32'(re), 32'({pe[k][o], 1'b0}));
    end else begin
      cmp({"rerror_idle_", s}, 32'(re), 32'd0);
    end
    cmp({"busy_", s}, 32'(bz), 32'(!m_ready[k]));
    cmp({"done_", s}, 32'(dn), 32'(m_done[k]));
    cmp({"err_valid_", s}, 32'(ev), 32'(m_errv[k]));
    cmp({"err_addr_", s}, 32'(ea), 32'(m_erra[k]));
  endtask

  always @(negedge clk) begin
    check_dut(0, gnt_a, rvalid_a, rdata_a, rerror_a, busy_a, done_a, errv_a, erra_a);
    check_dut(1, gnt_b, rvalid_b, rdata_b, rerror_b, busy_b, done_b, errv_b, erra_b);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [31:0] m);
    req = 1'b1; write = 1'b1; addr = a; wdata = d; wmask = m;
    step();
    req = 1'b0; write = 1'b0; wmask = '0;
  endtask

  // Read both instances; A answers one cycle after grant, B two.
  task automatic rd(input logic [8:0] a, input logic [31:0] ea, input logic [1:0] eea,
                    input logic [31:0] eb, input logic [1:0] eeb, input bit ca, input bit cb);
    req = 1'b1; write = 1'b0; addr = a;
    @(negedge clk);
    cmp("lit_gnt_a", 32'(gnt_a), 32'd1);
    step();
    req = 1'b0; err_clr_a = ca;
    @(negedge clk);
    cmp("lit_rvalid_a", 32'(rvalid_a), 32'd1);
    cmp("lit_rdata_a", rdata_a, ea);
    cmp("lit_rerror_a", 32'(rerror_a), 32'(eea));
    step();
    err_clr_a = 1'b0; err_clr_b = cb;
    @(negedge clk);
    cmp("lit_rvalid_b", 32'(rvalid_b), 32'd1);
    cmp("lit_rdata_b", rdata_b, eb);
    cmp("lit_rerror_b", 32'(rerror_b), 32'(eeb));
    step();
    err_clr_b = 1'b0;
  endtask

  task automatic count_init(input int exp_a, input int exp_b, input bit chk_gnt);
    int na = 0, nb = 0, ga = 0, gb = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (busy_a) na++;
      if (busy_b) nb++;
      if (!gnt_a) ga++;
      if (!gnt_b) gb++;
    end
    cmp("init_cycles_a", 32'(na), 32'(exp_a));
    cmp("init_cycles_b", 32'(nb), 32'(exp_b));
    if (chk_gnt) begin
      cmp("gnt_blocked_a", 32'(ga), 32'(exp_a));
      cmp("gnt_blocked_b", 32'(gb), 32'(exp_b));
    end
    cmp("lit_done_a", 32'(done_a), 32'd1);
    cmp("lit_done_b", 32'(done_b), 32'd1);
    step();
  endtask

  initial begin
    rst_n = 1'b0; init_req = 1'b0; err_clr_a = 1'b0; err_clr_b = 1'b0;
    req = 1'b1; write = 1'b0; addr = '0; wdata = '0; wmask = '0;
    repeat (2) @(negedge clk);
    cmp("rst_busy_a", 32'(busy_a), 32'd1);
    cmp("rst_gnt_a", 32'(gnt_a), 32'd0);
    cmp("rst_rdata_a", rdata_a, 32'd0);
    cmp("rst_rvalid_b", 32'(rvalid_b), 32'd0);
    cmp("rst_errv_b", 32'(errv_b), 32'd0);
    cmp("rst_done_b", 32'(done_b), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // req held through init: blocked exactly Depth cycles, then back-to-back reads
    count_init(512, 300, 1'b1);
    req = 1'b0;
    step(); step();

    rd(9'd0,   32'd0, 2'b00, 32'd0, 2'b00, 1'b0, 1'b0);
    rd(9'd255, 32'd0, 2'b00, 32'd0, 2'b00, 1'b0, 1'b0);
    rd(9'd511, 32'd0, 2'b00, 32'd0, 2'b00, 1'b0, 1'b0);

    wr(9'd5, 32'hDEADBEEF, 32'hFFFFFFFF);
    rd(9'd5, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 2'b00, 1'b0, 1'b0);

    wr(9'd12, 32'h0000CD00, 32'h0000FF00);
    rd(9'd12, 32'h0000CD00, 2'b00, 32'h0000CD00, 2'b00, 1'b0, 1'b0);

    // nibble write leaves stale parity -> error captured
    wr(9'd7, 32'h000000AB, 32'h0000000F);
    rd(9'd7, 32'h0000000B, 2'b10, 32'h0000000B, 2'b10, 1'b0, 1'b0);
    cmp("lit_errv_a", 32'(errv_a), 32'd1);
    cmp("lit_erra_a", 32'(erra_a), 32'd7);
    cmp("lit_erra_b", 32'(erra_b), 32'd7);

    wr(9'd9, 32'h00000001, 32'h0000000F);
    rd(9'd9, 32'h00000001, 2'b10, 32'h00000001, 2'b10, 1'b0, 1'b0);
    cmp("lit_erra_hold_a", 32'(erra_a), 32'd7);
    cmp("lit_erra_hold_b", 32'(erra_b), 32'd7);
    rd(9'd9, 32'h00000001, 2'b10, 32'h00000001, 2'b10, 1'b1, 1'b1);
    cmp("lit_cap_clr_errv_a", 32'(errv_a), 32'd1);
    cmp("lit_cap_clr_erra_a", 32'(erra_a), 32'd9);
    cmp("lit_cap_clr_erra_b", 32'(erra_b), 32'd9);

    err_clr_a = 1'b1; err_clr_b = 1'b1;
    step();
    err_clr_a = 1'b0; err_clr_b = 1'b0;
    cmp("lit_clr_errv_a", 32'(errv_a), 32'd0);
    cmp("lit_clr_errv_b", 32'(errv_b), 32'd0);

    // 310 is in range for A, out of range for B
    wr(9'd310, 32'h12345678, 32'hFFFFFFFF);
    rd(9'd310, 32'h12345678, 2'b00, 32'd0, 2'b00, 1'b0, 1'b0);
    rd(9'd54,  32'd0, 2'b00, 32'd0, 2'b00, 1'b0, 1'b0);
    rd(9'd299, 32'd0, 2'b00, 32'd0, 2'b00, 1'b0, 1'b0);

    req = 1'b1; write = 1'b0; addr = 9'd5; init_req = 1'b1;
    @(negedge clk);
    cmp("lit_initreq_gnt_a", 32'(gnt_a), 32'd0);
    cmp("lit_initreq_gnt_b", 32'(gnt_b), 32'd0);
    step();
    req = 1'b0; init_req = 1'b0;
    cmp("lit_reinit_done_a", 32'(done_a), 32'd0);
    repeat (20) step();
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    repeat (600) step();
    rd(9'd5, 32'd0, 2'b00, 32'd0, 2'b00, 1'b0, 1'b0);
    rd(9'd7, 32'd0, 2'b00, 32'd0, 2'b00, 1'b0, 1'b0);

    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    count_init(512, 300, 1'b0);
    rd(9'd12, 32'd0, 2'b00, 32'd0, 2'b00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish, expected finish before 1000000");
    $fatal(1);
  end

endmodule
